alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked ALU/shifter execution unit with a multi-cycle iterative shifter.
// Optional signed-overflow flag for add/sub is built only when ALU_EXEC_OVF_EN is defined.
module alu_exec_unit #(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  ALU_operation_i,
    input  logic [1:0]  FURslt_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [4:0]  shamt_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        overflow_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned STEP_W = 4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;

    localparam logic [1:0] SEL_ALU   = 2'b00;
    localparam logic [1:0] SEL_SHIFT = 2'b01;
    localparam logic [1:0] SEL_IMM   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                left_q, left_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                ready_q, valid_q;

    logic [DATA_W-1:0]   add_c, sub_c, alu_c, direct_c, shifted_c;
    logic                slt_c, shift_op_c, shift_start_c, accept_c;
    logic [STEP_W-1:0]   step_c;

    // Single-cycle datapath evaluated on the live request inputs
    always_comb begin
        add_c = src1_i + src2_i;
        sub_c = src1_i - src2_i;
        slt_c = $signed(src1_i) < $signed(src2_i);
        case (ALU_operation_i)
            OP_ADD:  alu_c = add_c;
            OP_SUB:  alu_c = sub_c;
            OP_AND:  alu_c = src1_i & src2_i;
            OP_OR:   alu_c = src1_i | src2_i;
            OP_NOR:  alu_c = ~(src1_i | src2_i);
            OP_SLT:  alu_c = DATA_W'(slt_c);
            default: alu_c = '0;
        endcase
    end

    always_comb begin
        accept_c      = in_valid_i && (state_q == IDLE);
        shift_op_c    = (FURslt_i == SEL_SHIFT) &&
                        ((ALU_operation_i == OP_SLL) || (ALU_operation_i == OP_SRL));
        shift_start_c = shift_op_c && (shamt_i != '0);
        case (FURslt_i)
            SEL_ALU:   direct_c = alu_c;
            // zero-distance shift passes the operand; unknown shift codes give 0
            SEL_SHIFT: direct_c = shift_op_c ? src2_i : '0;
            SEL_IMM:   direct_c = {src2_i[15:0], 16'h0000};
            default:   direct_c = '0;
        endcase
    end

    // Iterative shifter: at most SHIFT_STEP bits per cycle
    always_comb begin
        step_c    = (rem_q < CNT_W'(SHIFT_STEP)) ? STEP_W'(rem_q) : STEP_W'(SHIFT_STEP);
        shifted_c = left_q ? (work_q << step_c) : (work_q >> step_c);
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        left_d   = left_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    if (shift_start_c) begin
                        state_d = SHIFT;
                        work_d  = src2_i;
                        rem_d   = shamt_i;
                        left_d  = (ALU_operation_i == OP_SLL);
                    end else begin
                        state_d  = DONE;
                        result_d = direct_c;
                        zero_d   = (direct_c == '0);
                    end
                end
            end
            SHIFT: begin
                work_d = shifted_c;
                rem_d  = rem_q - CNT_W'(step_c);
                if (rem_q == CNT_W'(step_c)) begin
                    state_d  = DONE;
                    result_d = shifted_c;
                    zero_d   = (shifted_c == '0);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ready_q  <= (state_d == IDLE);
            valid_q  <= (state_d == DONE);
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;

`ifdef ALU_EXEC_OVF_EN
    logic ovf_c, ovf_q;

    always_comb begin
        ovf_c = 1'b0;
        if (FURslt_i == SEL_ALU) begin
            if (ALU_operation_i == OP_ADD) begin
                ovf_c = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                        (add_c[DATA_W-1] != src1_i[DATA_W-1]);
            end else if (ALU_operation_i == OP_SUB) begin
                ovf_c = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                        (sub_c[DATA_W-1] != src1_i[DATA_W-1]);
            end
        end
    end

    // Shifts never overflow; the flag holds with the result in DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (accept_c && !shift_start_c) begin
            ovf_q <= ovf_c;
        end else if (state_q == SHIFT) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow_o = ovf_q;
`else
    logic unused_accept;
    assign unused_accept = accept_c;
    assign overflow_o    = 1'b0;
`endif

endmodule
